// File: rtl/fifo_pop_stage.sv
// rtl/fifo_pop_stage.sv - FIFO read-side pop stage with a 2-entry skid buffer
// Pops the attached FIFO and presents entries on a registered valid/ready stream.
module fifo_pop_stage #(
  parameter int kWidth = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              fifo_read_en,
  input  logic [kWidth-1:0] fifo_read_data,
  input  logic              fifo_is_empty,
  input  logic              fifo_write_en,
  output logic              out_valid,
  output logic [kWidth-1:0] out_data,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [kWidth-1:0] slot0_q, slot0_d;
  logic [kWidth-1:0] slot1_q, slot1_d;
  logic              drain;
  logic              pop;

  // out_ready only reaches fifo_read_en when both slots are occupied.
  assign drain        = (state_q != EMPTY) && out_ready;
  assign fifo_read_en = rst && !flush && !fifo_is_empty && !fifo_write_en &&
                        ((state_q != TWO) || drain);
  assign pop          = fifo_read_en;

  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush) begin
      state_d = EMPTY;
      slot0_d = '0;
      slot1_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (pop) begin
            slot0_d = fifo_read_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (pop && !drain) begin
            slot1_d = fifo_read_data;
            state_d = TWO;
          end else if (pop && drain) begin
            slot0_d = fifo_read_data;
          end else if (drain) begin
            // slot0 is kept at zero while empty so out_data reads 0.
            slot0_d = '0;
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            slot0_d = slot1_q;
            if (pop) begin
              slot1_d = fifo_read_data;
            end else begin
              slot1_d = '0;
              state_d = ONE;
            end
          end
        end
        default: begin
          state_d = EMPTY;
          slot0_d = '0;
          slot1_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign out_data  = slot0_q;

endmodule
